mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction fetch) and the
//  MEM stage (load/store) of the 5-stage MIPS pipeline. Grants one transaction at a time
//  (data has priority), drives the memory-side request, and returns data with a one-cycle
//  ack pulse. Raises per-stage stall signals that the hazard logic ORs into the
//  pc/IF-ID/ID-EX enables. A watchdog reports memories that never answer.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  16  max WAIT cycles before abort (>=2); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1       pipeline clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request, held until if_ack
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  DATA_W  fetched instruction, valid with if_ack, held until next if_ack
//  if_ack     out  1       one-cycle completion pulse, registered
//  stall_if   out  1       if_req & ~if_ack (combinational)
//  d_req      in   1       data request, held until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address (EX/MEM ALU result)
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid with d_ack, held until next load ack
//  d_ack      out  1       one-cycle completion pulse, registered
//  stall_d    out  1       d_req & ~d_ack (combinational)
//  mem_en     out  1       one-cycle issue strobe, registered
//  mem_we     out  1       write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  latched address of the granted transaction
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       memory completion pulse
//  err        out  1       sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 (rdata registers included), counter 0, err 0.
//  - States: IDLE, WAIT_D, WAIT_I.
//  - IDLE: if d_req (ignoring a port whose ack is high this cycle) -> WAIT_D; else if
//    if_req (same exclusion) -> WAIT_I; else stay. On grant, the selected addr/we/wdata
//    are latched into mem_addr/mem_we/mem_wdata, and mem_en=1 in the next cycle only.
//    Fetch grants force mem_we=0.
//  - Requester inputs that change after the grant are ignored until the next grant.
//  - WAIT_x: mem_ready is accepted in any WAIT cycle, including the mem_en cycle.
//    On mem_ready -> IDLE. The next cycle pulses x_ack. For a load/fetch, x_rdata<=mem_rdata.
//    A store leaves d_rdata unchanged.
//  - Latency: req at cycle 0 with L = cycles from mem_en to mem_ready -> mem_en at cycle 1,
//    ack at cycle 2+L. The IDLE cycle that coincides with an ack can grant the other port.
//  - Simultaneous d_req and if_req: data always wins (it is the older instruction). Fetch
//    is granted in the first IDLE cycle with no unacked data request.
//  - Timeout: the counter resets on grant and increments every WAIT cycle. If it reaches
//    TIMEOUT without mem_ready -> IDLE, ack pulsed, rdata<=0, err<=1. mem_ready and timeout
//    in the same cycle: mem_ready wins.
//  - mem_ready while IDLE (late or spurious) is ignored; no state or output change.
//  - rst mid-WAIT: immediate return to IDLE with all outputs 0. A response that arrives
//    after reset is ignored per the previous rule.
// STRUCTURE
//  - mem_arb_defs.vh: state encodings (IDLE=2'd0, WAIT_D=2'd1, WAIT_I=2'd2) and the
//    timeout fill value (0).
//  - One sub-module, arb_timeout_ctr (clear / enable / expired), parameterised by TIMEOUT.
//  - Everything else stays in mem_port_arbiter: FSM, request latches, rdata/ack registers.
// TESTING
//  1. if_req=1, if_addr=0x40, model L=2 returns 0x8C010004 -> mem_en@1 with addr 0x40 and
//     we=0. if_ack@4 with if_rdata=0x8C010004. stall_if high cycles 0-3.
//  2. d_req (load 0x1000) and if_req (0x44) both at cycle 0, L=1 -> data issued @1, d_ack@3.
//     Fetch issued @4, if_ack@6. stall_if high until 6.
//  3. Store d_we=1, d_addr=0x2000, d_wdata=0x12345678 -> mem_we=1 with those values for
//     one mem_en cycle. d_ack pulses. d_rdata keeps its previous load value.
//  4. TIMEOUT=8, memory silent -> d_ack@10 with d_rdata=0 and err=1, held across later
//     good transactions until rst.
//  5. rst asserted in cycle 2 of a WAIT_I -> outputs 0 that cycle. mem_ready@4 ignored.
//     A fresh if_req after reset completes normally.
//  6. if_req held high through its ack cycle -> exactly one mem_en per request. No
//     duplicate issue. mem_ready in the mem_en cycle (L=0) -> ack on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter:
// FSM state encodings and the read-data value returned on a watchdog abort.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_D = 2'd1,
        ST_WAIT_I = 2'd2
    } arb_state_t;

    // Bit value replicated across rdata when a transaction is aborted by the watchdog.
    localparam logic TIMEOUT_FILL = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog counter for one outstanding memory transaction: cleared on grant,
// counts WAIT cycles and saturates at TIMEOUT, flagging expiry.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store,
// data first; registered acks, latched memory request, sticky watchdog error.
//
// state     | meaning
// ST_IDLE   | no transaction outstanding, may grant D (priority) or I
// ST_WAIT_D | data transaction issued, waiting for mem_ready or timeout
// ST_WAIT_I | fetch transaction issued, waiting for mem_ready or timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_d,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic              r_err;

    logic              w_d_pending;
    logic              w_i_pending;
    logic              w_waiting;
    logic              w_expired;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_done_d;
    logic              w_done_i;
    logic              w_abort;

    // A port whose ack is high this cycle is still holding its finished request.
    assign w_d_pending = d_req  && !r_d_ack;
    assign w_i_pending = if_req && !r_if_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_pending)      w_state_nxt = ST_WAIT_D;
                else if (w_i_pending) w_state_nxt = ST_WAIT_I;
            end
            ST_WAIT_D, ST_WAIT_I: begin
                if (mem_ready || w_expired) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_waiting = (r_state == ST_WAIT_D) || (r_state == ST_WAIT_I);
        w_grant_d = (r_state == ST_IDLE) && w_d_pending;
        w_grant_i = (r_state == ST_IDLE) && !w_d_pending && w_i_pending;
        w_done_d  = (r_state == ST_WAIT_D) && (mem_ready || w_expired);
        w_done_i  = (r_state == ST_WAIT_I) && (mem_ready || w_expired);
        w_abort   = w_waiting && w_expired && !mem_ready;
    end

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_grant_d || w_grant_i),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_en <= w_grant_d || w_grant_i;
            r_if_ack <= w_done_i;
            r_d_ack  <= w_done_d;
            if (w_grant_d) begin
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
            end
            if (w_done_i) begin
                r_if_rdata <= w_abort ? {DATA_W{TIMEOUT_FILL}} : mem_rdata;
            end
            // Stores keep the last load value unless the watchdog aborts them.
            if (w_done_d && (w_abort || !r_mem_we)) begin
                r_d_rdata <= w_abort ? {DATA_W{TIMEOUT_FILL}} : mem_rdata;
            end
            if (w_abort) r_err <= 1'b1;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign err       = r_err;
    assign stall_if  = if_req && !r_if_ack;
    assign stall_d   = d_req  && !r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// memory issues and acks; a monitor pops and compares them as the DUT produces them.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        stall_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        stall_d;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        err;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall_d(stall_d),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } ack_exp_t;

    mem_exp_t q_mem[$];
    ack_exp_t q_iack[$];
    ack_exp_t q_dack[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int mem_lat  = -1;
    int mem_cnt  = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", nm, act, exp, cyc - t0);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic mem_exp_t mk_mem(input int c, input logic [31:0] a,
                                        input logic w, input logic [31:0] wd);
        mem_exp_t e;
        e.cyc = c; e.addr = a; e.we = w; e.wdata = wd;
        return e;
    endfunction

    function automatic ack_exp_t mk_ack(input int c, input logic [31:0] rd, input logic e_err);
        ack_exp_t e;
        e.cyc = c; e.rdata = rd; e.err = e_err;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers L cycles after mem_en; silent when mem_lat < 0.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_en && mem_lat >= 0) mem_cnt = mem_lat;
            if (mem_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_val(mem_addr);
                mem_cnt   = -1;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_en) begin
                if (q_mem.size() == 0) chk("mem_en_unexpected", 1, 0);
                else begin
                    mem_exp_t e;
                    e = q_mem.pop_front();
                    chk("mem_en_cycle", 64'(cyc - t0), 64'(e.cyc));
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", mem_we, e.we);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (if_ack) begin
                if (q_iack.size() == 0) chk("if_ack_unexpected", 1, 0);
                else begin
                    ack_exp_t e;
                    e = q_iack.pop_front();
                    chk("if_ack_cycle", 64'(cyc - t0), 64'(e.cyc));
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_err", err, e.err);
                end
            end
            if (d_ack) begin
                if (q_dack.size() == 0) chk("d_ack_unexpected", 1, 0);
                else begin
                    ack_exp_t e;
                    e = q_dack.pop_front();
                    chk("d_ack_cycle", 64'(cyc - t0), 64'(e.cyc));
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", err, e.err);
                end
            end
        end
    end

    task automatic start_test();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_if(input logic [31:0] a);
        bit got = 0;
        if_req  = 1'b1;
        if_addr = a;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (if_ack) got = 1;
        end
        if (!got) chk("if_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic run_d(input logic w, input logic [31:0] a, input logic [31:0] wd);
        bit got = 0;
        d_req   = 1'b1;
        d_we    = w;
        d_addr  = a;
        d_wdata = wd;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (d_ack) got = 1;
        end
        if (!got) chk("d_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic watch_stall_if(input int last_high);
        for (int r = 0; r <= last_high + 1; r++) begin
            @(negedge clk);
            chk("stall_if", stall_if, 64'(r <= last_high));
        end
    endtask

    task automatic watch_stall_d(input int last_high);
        for (int r = 0; r <= last_high + 1; r++) begin
            @(negedge clk);
            chk("stall_d", stall_d, 64'(r <= last_high));
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_mem_en"},    mem_en, 0);
        chk({nm, "_mem_we"},    mem_we, 0);
        chk({nm, "_mem_addr"},  mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_if_rdata"},  if_rdata, 0);
        chk({nm, "_d_rdata"},   d_rdata, 0);
        chk({nm, "_acks"},      {if_ack, d_ack}, 0);
        chk({nm, "_err"},       err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        idle(3);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 1: fetch, L=2
        mem_lat = 2;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h40, 1'b0, 32'h0));
        q_iack.push_back(mk_ack(4, 32'h8C01_0004, 1'b0));
        fork
            run_if(32'h40);
            watch_stall_if(3);
        join
        idle(3);

        // 2: simultaneous data load and fetch, L=1
        mem_lat = 1;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h1000, 1'b0, 32'h0));
        q_dack.push_back(mk_ack(3, 32'hA5A5_1000, 1'b0));
        q_mem.push_back(mk_mem(4, 32'h44, 1'b0, 32'h0));
        q_iack.push_back(mk_ack(6, 32'hA5A5_0044, 1'b0));
        fork
            run_d(1'b0, 32'h1000, 32'h0);
            run_if(32'h44);
            watch_stall_if(5);
            watch_stall_d(2);
        join
        idle(3);

        // 3: store keeps previous load data
        mem_lat = 1;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h2000, 1'b1, 32'h1234_5678));
        q_dack.push_back(mk_ack(3, 32'hA5A5_1000, 1'b0));
        run_d(1'b1, 32'h2000, 32'h1234_5678);
        idle(3);

        // 4: silent memory, watchdog abort, sticky err
        mem_lat = -1;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h3000, 1'b0, 32'h0));
        q_dack.push_back(mk_ack(10, 32'h0, 1'b1));
        run_d(1'b0, 32'h3000, 32'h0);
        idle(3);
        mem_lat = 1;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h48, 1'b0, 32'h0));
        q_iack.push_back(mk_ack(3, 32'hA5A5_0048, 1'b1));
        run_if(32'h48);
        idle(2);
        chk("err_sticky", err, 1);

        // 5: reset in cycle 2 of a fetch wait; late mem_ready at cycle 4 ignored
        mem_lat = 3;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h4C, 1'b0, 32'h0));
        if_req  = 1'b1;
        if_addr = 32'h4C;
        idle(2);
        rst = 1'b1;
        if_req = 1'b0;
        #1;
        chk_outputs_zero("midwait_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 4; r <= 6; r++) begin
            @(negedge clk);
            chk("post_rst_if_ack", if_ack, 0);
            chk("post_rst_mem_en", mem_en, 0);
            chk("post_rst_err", err, 0);
        end
        idle(2);
        mem_lat = 2;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h40, 1'b0, 32'h0));
        q_iack.push_back(mk_ack(4, 32'h8C01_0004, 1'b0));
        run_if(32'h40);
        idle(3);

        // 6: L=0, request held through ack cycle issues once
        mem_lat = 0;
        start_test();
        q_mem.push_back(mk_mem(1, 32'h50, 1'b0, 32'h0));
        q_iack.push_back(mk_ack(2, 32'hA5A5_0050, 1'b0));
        run_if(32'h50);
        idle(4);
        start_test();
        q_mem.push_back(mk_mem(1, 32'h60, 1'b0, 32'h0));
        q_dack.push_back(mk_ack(2, 32'hA5A5_0060, 1'b0));
        run_d(1'b0, 32'h60, 32'h0);
        idle(6);

        chk("q_mem_empty",  q_mem.size(), 0);
        chk("q_iack_empty", q_iack.size(), 0);
        chk("q_dack_empty", q_dack.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
